// File: rtl/uart_pkg.sv
// uart_pkg: shared types and sizing helpers for the UART byte receiver.
// No logic; latency and backpressure are properties of the modules that import it.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic int calc_bit_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_cnt_w(input int bit_cnt);
    return (bit_cnt > 1) ? $clog2(bit_cnt) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer plus registered falling-edge detect on rx.
// Latency: level 2 clk, fall pulse 3 clk after rx is first registered low; no backpressure.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_lvl,
  output logic fall
);

  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;
  logic rx_prev_q, rx_prev_d;
  logic fall_q, fall_d;

  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    fall_d    = rx_prev_q & ~rx_sync_q;
  end

  // Line flops reset to idle-high so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      fall_q    <= fall_d;
    end
  end

  assign rx_lvl = rx_sync_q;
  assign fall   = fall_q;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver, 8E1 when UART_RX_PARITY_EN is defined; 1-cycle result strobes.
// Latency 3+BIT_CNT/2+9*BIT_CNT clk (10*BIT_CNT with parity) from rx registered low; no backpressure.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] po_data,
  output logic              rx_down,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int CNT_W = calc_cnt_w(BIT_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CNT / 2 - 1);

  logic rx_lvl;
  logic fall;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .rx_lvl (rx_lvl),
    .fall   (fall)
  );

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] po_data_q, po_data_d;
  logic              rx_down_q, rx_down_d;
  logic              frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == IDLE || cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    po_data_d   = po_data_q;
    rx_down_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = START;
          cnt_d     = '0;
          bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      START: begin
        // Realign the counter at mid-start so every later sample lands mid-bit.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_lvl ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d   = {rx_lvl, shift_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_bad_d = rx_lvl ^ (^shift_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          if (!rx_lvl) begin
            frame_err_d = 1'b1;
          end else begin
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              rx_down_d = 1'b1;
              po_data_d = shift_q;
            end
`else
            rx_down_d = 1'b1;
            po_data_d = shift_q;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      po_data_q   <= '0;
      rx_down_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      po_data_q   <= po_data_d;
      rx_down_q   <= rx_down_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign po_data   = po_data_q;
  assign rx_down   = rx_down_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx at BIT_CNT = 10: frame-level model predicts strobe cycles and po_data.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 format.
module tb_uart_byte_rx;
  import uart_pkg::*;

  localparam int BIT = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam int LAT   = 3 + BIT / 2 + 10 * BIT;
`else
  localparam int NBITS = 10;
  localparam int LAT   = 3 + BIT / 2 + 9 * BIT;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] po_data;
  logic       rx_down, frame_err, parity_err;

  uart_byte_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .po_data    (po_data),
    .rx_down    (rx_down),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  int checks = 0;
  int errors = 0;

  // Expected strobe per cycle: 1 = rx_down, 2 = frame_err, 3 = parity_err.
  int         exp_kind[int];
  logic [7:0] exp_data[int];
  logic [7:0] model_po = 8'h00;
  int n_rx = 0, n_ferr = 0, n_perr = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      int kind;
      kind = exp_kind.exists(cyc) ? exp_kind[cyc] : 0;
      if (rst_at_edge) model_po = 8'h00;
      if (kind == 1) model_po = exp_data[cyc];
      check("rx_down",    int'(rx_down),    int'(kind == 1));
      check("frame_err",  int'(frame_err),  int'(kind == 2));
      check("parity_err", int'(parity_err), int'(kind == 3));
      check("po_data",    int'(po_data),    int'(model_po));
      if (rx_down)    n_rx++;
      if (frame_err)  n_ferr++;
      if (parity_err) n_perr++;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // rst_bit: frame bit index (0 = start, 1..8 = D0..D7) during which rst pulses; -1 for none.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input int kind, input int rst_bit);
    int t0;
    logic v;
    t0 = cyc + 1;
    if (kind != 0) begin
      exp_kind[t0 + LAT] = kind;
      exp_data[t0 + LAT] = d;
    end
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)              v = 1'b0;
      else if (b <= 8)         v = d[b-1];
      else if (b == NBITS - 1) v = stop_b;
      else                     v = par_b;
      rx = v;
      if (b == rst_bit) begin
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (BIT - 6) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b1, ^d, 1, -1);
  endtask

  logic [7:0] last_byte;

  initial begin
    repeat (3) @(negedge clk);
    check("reset po_data",    int'(po_data),    0);
    check("reset rx_down",    int'(rx_down),    0);
    check("reset frame_err",  int'(frame_err),  0);
    check("reset parity_err", int'(parity_err), 0);
    rst = 1'b0;
    idle(20);

    // "A1" back-to-back
    send_good(8'h41);
    send_good(8'h31);
    idle(5);
    check("A1 rx count", n_rx, 2);
    check("A1 po_data", int'(po_data), 8'h31);
    check("A1 no frame_err", n_ferr, 0);

    // 3-cycle glitch
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check("glitch state idle", int'(dut.state_q == IDLE), 1);
    check("glitch rx count", n_rx, 2);
    check("glitch po_data", int'(po_data), 8'h31);

    // Framing error, then line held low
    send_frame(8'h42, 1'b0, ^8'h42, 2, -1);
    rx = 1'b0;
    repeat (150) @(negedge clk);
    check("ferr count", n_ferr, 1);
    check("ferr rx count", n_rx, 2);
    check("ferr po_data", int'(po_data), 8'h31);
    idle(20);

    // Reset during D4; D4..D7 high keeps the line idle-looking afterwards
    send_frame(8'hF0, 1'b1, ^8'hF0, 0, 5);
    idle(120);
    check("rst po_data", int'(po_data), 8'h00);
    check("rst rx count", n_rx, 2);
    send_good(8'h30);
    idle(5);
    check("after rst po_data", int'(po_data), 8'h30);
    check("after rst rx count", n_rx, 3);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h41, 1'b1, 1'b0, 1, -1);
    idle(5);
    check("par ok po_data", int'(po_data), 8'h41);
    send_frame(8'h41, 1'b1, 1'b1, 3, -1);
    idle(5);
    check("par bad count", n_perr, 1);
    check("par bad rx count", n_rx, 4);
    idle(10);
`endif

    // Stress: 16 random bytes, no idle gap
    begin
      int base;
      base = n_rx;
      last_byte = 8'h00;
      for (int i = 0; i < 16; i++) begin
        last_byte = 8'($urandom_range(255, 0));
        send_good(last_byte);
      end
      idle(5);
      check("stress rx count", n_rx - base, 16);
      check("stress last po_data", int'(po_data), int'(last_byte));
    end

    idle(150);
    check("total frame_err", n_ferr, 1);
`ifndef UART_RX_PARITY_EN
    check("total parity_err", n_perr, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
